// File: rtl/a51_pkg.sv
// a51_pkg: shared types and constants for the A5/1 stream engine.
// FSM state type, LFSR lengths, feedback tap masks, clock-bit indices
// and the majority helper used by the irregular clocking rule.
package a51_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADK,
        LOADF,
        MIX,
        RUN,
        DONE
    } a51_state_t;

    localparam int unsigned R1_LEN = 19;
    localparam int unsigned R2_LEN = 22;
    localparam int unsigned R3_LEN = 23;

    // Feedback taps: R1 {18,17,16,13}, R2 {21,20}, R3 {22,21,20,7}
    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

    localparam int unsigned R1_CLK = 8;
    localparam int unsigned R2_CLK = 10;
    localparam int unsigned R3_CLK = 10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a51_stream_engine_if.sv
// a51_stream_engine_if: keystream word handshake (valid/ready, word, last).
// master = engine side, slave = downstream packer side.
interface a51_stream_engine_if #(
    parameter int unsigned OUT_W = 4
);

    logic             ks_valid;
    logic             ks_ready;
    logic [OUT_W-1:0] ks_word;
    logic             ks_last;

    modport master (
        output ks_valid,
        output ks_word,
        output ks_last,
        input  ks_ready
    );

    modport slave (
        input  ks_valid,
        input  ks_word,
        input  ks_last,
        output ks_ready
    );

endinterface

// File: rtl/a51_clocked_lfsr.sv
// a51_clocked_lfsr: one A5/1 shift register. Shifts toward the MSB with the
// tap parity (optionally XORed with a load bit) entering bit 0 when enabled.
module a51_clocked_lfsr #(
    parameter int unsigned     LEN     = 19,
    parameter logic [LEN-1:0]  TAPS    = '0,
    parameter int unsigned     CLK_BIT = 0
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           clr,
    input  logic           en,
    input  logic           load_bit,
    input  logic           load_mode,
    output logic [LEN-1:0] state,
    output logic           clk_bit
);

    logic fb;

    // Feedback bit: tap parity, plus the load bit during key/frame loading
    always_comb begin
        fb      = (^(state & TAPS)) ^ (load_mode & load_bit);
        clk_bit = state[CLK_BIT];
    end

    // Register update: clear on run start, shift when enabled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= '0;
        end else if (clr) begin
            state <= '0;
        end else if (en) begin
            state <= {state[LEN-2:0], fb};
        end
    end

endmodule

// File: rtl/a51_stream_engine.sv
// a51_stream_engine: A5/1 keystream generator with valid/ready output,
// abort and done pulse. Optional feature macro: A51_FRAME_AUTOINC_EN
// (adds frame_load and an auto-incrementing internal frame register).
module a51_stream_engine
    import a51_pkg::*;
#(
    parameter int unsigned KEY_BITS   = 64,
    parameter int unsigned FRAME_BITS = 22,
    parameter int unsigned MIX_CYCLES = 100,
    parameter int unsigned KS_BITS    = 228,
    parameter int unsigned OUT_W      = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
`ifdef A51_FRAME_AUTOINC_EN
    input  logic                  frame_load,
`endif
    a51_stream_engine_if.master   ks,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned MAX_KF  = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int unsigned MAX_MK  = (MIX_CYCLES > KS_BITS) ? MIX_CYCLES : KS_BITS;
    localparam int unsigned CNT_MAX = (MAX_KF > MAX_MK) ? MAX_KF : MAX_MK;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned KI_W    = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam int unsigned FI_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned PK_W    = $clog2(OUT_W);

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] KS_END     = CNT_W'(KS_BITS);
    localparam logic [CNT_W-1:0] KS_LASTBIT = CNT_W'(KS_BITS - 1);
    localparam logic [PK_W-1:0]  PK_LAST    = PK_W'(OUT_W - 1);

    if ((KS_BITS % OUT_W) != 0) begin : g_bad_ks_bits
        $error("a51_stream_engine: KS_BITS must be a multiple of OUT_W");
    end
    if (OUT_W < 2) begin : g_bad_out_w
        $error("a51_stream_engine: OUT_W must be at least 2");
    end

    a51_state_t state, state_next;

    logic [CNT_W-1:0]      cnt;
    logic [KEY_BITS-1:0]   key_reg;
    logic [FRAME_BITS-1:0] frame_reg;
    logic [OUT_W-2:0]      pack_reg;
    logic [PK_W-1:0]       pack_cnt;
    logic [OUT_W-1:0]      word_q;
    logic                  valid_q;
    logic                  last_q;

    logic [R1_LEN-1:0] r1;
    logic [R2_LEN-1:0] r2;
    logic [R3_LEN-1:0] r3;
    logic              c1, c2, c3;
    logic              en1, en2, en3;

    logic             start_ok;
    logic             load_mode;
    logic             load_bit;
    logic             maj;
    logic             accept;
    logic             word_done;
    logic             stall;
    logic             adv;
    logic             mix_step;
    logic             ks_bit;
    logic [OUT_W-1:0] pack_next;
    logic             unused_lfsr_bits;

    // Datapath control: load bits, majority clocking, stall and keystream bit
    always_comb begin
        start_ok  = (state == IDLE) && start && !abort;
        load_mode = (state == LOADK) || (state == LOADF);
        load_bit  = (state == LOADK) ? key_reg[cnt[KI_W-1:0]] : frame_reg[cnt[FI_W-1:0]];
        maj       = maj3(c1, c2, c3);
        accept    = valid_q & ks.ks_ready;
        word_done = (pack_cnt == PK_LAST);
        stall     = valid_q & ~ks.ks_ready & word_done;
        adv       = (state == RUN) && (cnt < KS_END) && !stall;
        mix_step  = (state == MIX) || adv;
        en1       = load_mode | (mix_step & (c1 == maj));
        en2       = load_mode | (mix_step & (c2 == maj));
        en3       = load_mode | (mix_step & (c3 == maj));
        // Output bit is taken from the post-clock state: after a shift the
        // new MSB is the old MSB-1, otherwise the MSB is unchanged.
        ks_bit    = (en1 ? r1[R1_LEN-2] : r1[R1_LEN-1])
                  ^ (en2 ? r2[R2_LEN-2] : r2[R2_LEN-1])
                  ^ (en3 ? r3[R3_LEN-2] : r3[R3_LEN-1]);
        pack_next = {pack_reg, ks_bit};
        // Registers expose their full state; only a few bits feed the datapath.
        unused_lfsr_bits = ^{r1, r2, r3};
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)             state_next = LOADK;
            LOADK:   if (cnt == KEY_LAST)   state_next = LOADF;
            LOADF:   if (cnt == FRAME_LAST) state_next = MIX;
            MIX:     if (cnt == MIX_LAST)   state_next = RUN;
            RUN:     if (accept && last_q)  state_next = DONE;
            DONE:                           state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase counter: restarts on every state change, counts cycles or RUN bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if ((state inside {LOADK, LOADF, MIX}) || adv) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Key capture at start; frame source depends on the auto-increment option
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_reg   <= '0;
            frame_reg <= '0;
        end else begin
            if (start_ok) begin
                key_reg <= key;
            end
`ifdef A51_FRAME_AUTOINC_EN
            if ((state == IDLE) && frame_load) begin
                frame_reg <= frame;
            end else if (state == DONE) begin
                frame_reg <= frame_reg + 1'b1;
            end
`else
            if (start_ok) begin
                frame_reg <= frame;
            end
`endif
        end
    end

    // Packer and output register with valid/ready handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pack_reg <= '0;
            pack_cnt <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else if (start_ok || abort) begin
            pack_reg <= '0;
            pack_cnt <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (accept) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            if (adv) begin
                pack_reg <= pack_next[OUT_W-2:0];
                if (word_done) begin
                    pack_cnt <= '0;
                    word_q   <= pack_next;
                    valid_q  <= 1'b1;
                    last_q   <= (cnt == KS_LASTBIT);
                end else begin
                    pack_cnt <= pack_cnt + 1'b1;
                end
            end
        end
    end

    // Output drive
    always_comb begin
        ks.ks_valid = valid_q;
        ks.ks_word  = word_q;
        ks.ks_last  = last_q;
        busy        = (state != IDLE);
        done        = (state == DONE);
    end

    a51_clocked_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
        .clk(clk), .resetn(resetn), .clr(start_ok), .en(en1),
        .load_bit(load_bit), .load_mode(load_mode), .state(r1), .clk_bit(c1)
    );

    a51_clocked_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
        .clk(clk), .resetn(resetn), .clr(start_ok), .en(en2),
        .load_bit(load_bit), .load_mode(load_mode), .state(r2), .clk_bit(c2)
    );

    a51_clocked_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
        .clk(clk), .resetn(resetn), .clr(start_ok), .en(en3),
        .load_bit(load_bit), .load_mode(load_mode), .state(r3), .clk_bit(c3)
    );

endmodule

// File: tb/tb_a51_stream_engine.sv
// tb_a51_stream_engine: directed + randomized checks of a51_stream_engine
// against the published GSM vector and an algorithmic A5/1 model.
module tb_a51_stream_engine;

    localparam logic [63:0] GSM_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0] GSM_FRAME = 22'h134;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [63:0] key;
    logic [21:0] frame;
`ifdef A51_FRAME_AUTOINC_EN
    logic        frame_load;
`endif
    logic        busy;
    logic        done;

    a51_stream_engine_if #(.OUT_W(4)) ks_if ();

    a51_stream_engine #(
        .KEY_BITS(64), .FRAME_BITS(22), .MIX_CYCLES(100), .KS_BITS(228), .OUT_W(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .abort(abort),
        .key(key),
        .frame(frame),
`ifdef A51_FRAME_AUTOINC_EN
        .frame_load(frame_load),
`endif
        .ks(ks_if),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] got[$];
    logic [3:0] exp_w[$];
    int acc_cnt;
    int done_cnt;
    int lat;
    bit busy_after;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected words for the published GSM vector: 114 bits A->B then 114 bits B->A
    function automatic void build_gsm();
        logic [111:0] a2b;
        logic [119:0] b2a;
        logic [227:0] v;
        a2b = 112'h534EAA582FE8151AB6E1855A728C;
        b2a = 120'h24FD35A35D5FB6526D32F906DF1AC0;
        v = {a2b, 2'b00, b2a[119:6]};
        exp_w.delete();
        for (int j = 0; j < 57; j++) begin
            exp_w.push_back(v[227 - 4*j -: 4]);
        end
    endfunction

    // Algorithmic A5/1: load 64 key + 22 frame bits, 100 discarded majority
    // steps, then 228 output bits grouped MSB-first into 4-bit words.
    function automatic void build_model(input logic [63:0] k, input logic [21:0] f);
        logic [18:0] a;
        logic [21:0] b;
        logic [22:0] c;
        logic [3:0]  w;
        logic        lb;
        logic        m;
        int          votes;
        int          j;
        exp_w.delete();
        a = '0; b = '0; c = '0; w = '0;
        for (int i = 0; i < 86; i++) begin
            j = i - 64;
            lb = (i < 64) ? k[i[5:0]] : f[j[4:0]];
            a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ lb};
            b = {b[20:0], b[21] ^ b[20] ^ lb};
            c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ lb};
        end
        for (int i = 0; i < 328; i++) begin
            votes = int'(a[8]) + int'(b[10]) + int'(c[10]);
            m = (votes >= 2);
            if (a[8] == m) a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
            if (b[10] == m) b = {b[20:0], b[21] ^ b[20]};
            if (c[10] == m) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
            if (i >= 100) begin
                w = {w[2:0], a[18] ^ b[21] ^ c[22]};
                if (((i - 100) % 4) == 3) exp_w.push_back(w);
            end
        end
    endfunction

    // One complete run from IDLE. mode 0: ready=1; 1: toggling with a
    // 50-cycle hold low; 2: random ready. Optional start pulses mid-run/on done.
    task automatic run(input logic [63:0] k, input logic [21:0] f, input int mode,
                       input int pulse_at, input bit pulse_done);
        int   cyc;
        bit   seen_done;
        bit   prev_stall;
        logic [4:0] prev_out;
        got.delete();
        acc_cnt = 0; done_cnt = 0; lat = -1; seen_done = 0; prev_stall = 0;
        prev_out = '0; busy_after = 0;
        key = k; frame = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!seen_done && cyc < 3000) begin
            if (done) begin
                done_cnt++;
                seen_done = 1;
                if (pulse_done) start = 1'b1;
            end else begin
                case (mode)
                    0:       ks_if.ks_ready = 1'b1;
                    1:       ks_if.ks_ready = (cyc >= 230 && cyc < 280) ? 1'b0 : cyc[0];
                    default: ks_if.ks_ready = ($urandom_range(0, 99) < 70);
                endcase
                start = (cyc == pulse_at);
                if (prev_stall) chk("stable_while_stalled", {ks_if.ks_last, ks_if.ks_word}, prev_out);
                if (ks_if.ks_valid && lat < 0) lat = cyc;
                if (ks_if.ks_valid && ks_if.ks_ready) begin
                    got.push_back(ks_if.ks_word);
                    acc_cnt++;
                end
                prev_stall = ks_if.ks_valid && !ks_if.ks_ready;
                prev_out = {ks_if.ks_last, ks_if.ks_word};
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("done_within_budget", seen_done, 1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 5; t++) begin
            if (done) done_cnt++;
            if (busy) busy_after = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_accepts"}, acc_cnt, 57);
        chk({tag, "_nwords"}, got.size(), 57);
        for (int i = 0; i < 57; i++) begin
            if (i < got.size()) chk($sformatf("%s_word%0d", tag, i), got[i], exp_w[i]);
        end
        chk({tag, "_single_done"}, done_cnt, 1);
        chk({tag, "_idle_after"}, busy_after, 0);
    endtask

    initial begin
        bit done_seen;
        logic [63:0] rk;
        logic [21:0] rf;

        resetn = 1'b0; start = 1'b0; abort = 1'b0; key = '0; frame = '0;
        ks_if.ks_ready = 1'b0;
`ifdef A51_FRAME_AUTOINC_EN
        frame_load = 1'b0;
`endif
        #12;
        chk("rst_valid", ks_if.ks_valid, 0);
        chk("rst_word", ks_if.ks_word, 0);
        chk("rst_last", ks_if.ks_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // GSM vector, full ready
        build_gsm();
        run(GSM_KEY, GSM_FRAME, 0, -1, 0);
        chk("gsm_latency", lat, 191);
        check_words("gsm");

        // Same vector under backpressure
        run(GSM_KEY, GSM_FRAME, 1, -1, 0);
        check_words("bp");

        // Abort during MIX
        key = GSM_KEY; frame = GSM_FRAME; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (119) begin @(posedge clk); #1; end
        chk("abort_busy_before", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", ks_if.ks_valid, 0);
        done_seen = 0;
        for (int t = 0; t < 10; t++) begin
            if (done || busy) done_seen = 1;
            @(posedge clk); #1;
        end
        chk("abort_no_done", done_seen, 0);
        run(GSM_KEY, GSM_FRAME, 0, -1, 0);
        check_words("restart");

        // Asynchronous reset mid-RUN
        key = GSM_KEY; frame = GSM_FRAME; start = 1'b1; ks_if.ks_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (199) begin @(posedge clk); #1; end
        chk("midrun_valid_pre", ks_if.ks_valid, 1);
        resetn = 1'b0;
        #1;
        chk("arst_valid", ks_if.ks_valid, 0);
        chk("arst_word", ks_if.ks_word, 0);
        chk("arst_last", ks_if.ks_last, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        run(GSM_KEY, GSM_FRAME, 0, -1, 0);
        check_words("post_reset");

        // Start pulses during LOADF and on the done cycle are ignored
        run(GSM_KEY, GSM_FRAME, 0, 70, 1);
        check_words("ignored_start");

        // Randomized keys/frames with random backpressure
        for (int r = 0; r < 3; r++) begin
            rk = {$urandom(), $urandom()};
            rf = 22'($urandom());
            build_model(rk, rf);
            run(rk, rf, 2, -1, 0);
            check_words($sformatf("rand%0d", r));
        end

`ifdef A51_FRAME_AUTOINC_EN
        frame = 22'h3FFFFF; frame_load = 1'b1;
        @(posedge clk); #1;
        frame_load = 1'b0;
        rk = {$urandom(), $urandom()};
        build_model(rk, 22'h3FFFFF);
        run(rk, 22'h0ABCDE, 0, -1, 0);
        check_words("autoinc_first");
        build_model(rk, 22'h000000);
        run(rk, 22'h155555, 0, -1, 0);
        check_words("autoinc_wrap");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
